// File: rtl/bit_change.sv
// Single-bit inverter: registers A with bit B flipped, or flags an error when
// B (signed) lies outside 0..N-1. One-cycle latency, accepts a request every cycle.
module bit_change #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic signed [N-1:0] A,
    input  logic signed [N-1:0] B,
    output logic signed [N-1:0] result,
    output logic                error,
    output logic                valid_out
);

    // Index is widened (sign-extended) so the range check never truncates B.
    localparam int IW = (N > 32) ? N : 32;

    function automatic logic idx_ok(input logic signed [N-1:0] idx);
        logic signed [IW-1:0] ix;
        ix = IW'(idx);
        return (ix >= IW'(0)) && (ix < IW'(N));
    endfunction

    function automatic logic signed [N-1:0] flip_bit(input logic signed [N-1:0] a,
                                                     input logic signed [N-1:0] idx);
        logic signed [IW-1:0] ix;
        logic        [N-1:0]  mask;
        ix   = IW'(idx);
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (ix == IW'(i));
        end
        return a ^ mask;
    endfunction

    logic signed [N-1:0] res_p0;
    logic                err_p0;

    always_comb begin
        err_p0 = !idx_ok(B);
        res_p0 = err_p0 ? '0 : flip_bit(A, B);
    end

    // p0 -> output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            error     <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result <= res_p0;
                error  <= err_p0;
            end
        end
    end

endmodule

// File: tb/tb_bit_change.sv
// Self-checking bench for bit_change: expected results are queued at drive time
// and popped when the corresponding output is sampled on the falling edge.
module tb_bit_change;

    localparam int N = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_in;
    logic signed [N-1:0] A;
    logic signed [N-1:0] B;
    logic signed [N-1:0] result;
    logic                error;
    logic                valid_out;

    typedef struct packed {
        logic [N-1:0] res;
        logic         err;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bit_change #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .A        (A),
        .B        (B),
        .result   (result),
        .error    (error),
        .valid_out(valid_out)
    );

    function automatic exp_t model(input logic [N-1:0] a, input int b);
        exp_t e;
        if (b < 0 || b >= N) begin
            e.res = '0;
            e.err = 1'b1;
        end else begin
            e.res = a ^ (N'(1) << b);
            e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic drive(input logic [N-1:0] a, input int b);
        A        = a;
        B        = b[N-1:0];
        valid_in = 1'b1;
        sbq.push_back(model(a, b));
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        valid_in = 1'b0;
        A        = 8'hFF;
        B        = 8'sd3;
        #2;
        checks++;
        if (result !== 8'h00 || error !== 1'b0 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got result=%h error=%b valid_out=%b, expected 00 0 0",
                     result, error, valid_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (result !== 8'h00 || error !== 1'b0 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got result=%h error=%b valid_out=%b, expected 00 0 0",
                     result, error, valid_out);
        end
    endtask

    task automatic test_single();
        int   bs[8] = '{0, 2, -2, 9, 8, -128, 7, 5};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drive(8'b10101010, bs[i]);
            @(negedge clk);
            valid_in = 1'b0;
            e = sbq.pop_front();
            checks++;
            if (valid_out !== 1'b1 || result !== e.res || error !== e.err) begin
                failures++;
                $display("FAIL single_B%0d: got result=%b error=%b valid_out=%b, expected result=%b error=%b valid_out=1",
                         bs[i], result, error, valid_out, e.res, e.err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive(8'b10101010, 7);
        @(negedge clk);
        valid_in = 1'b0;
        A        = 8'h55;
        B        = -8'sd1;
        e = sbq.pop_front();
        checks++;
        if (valid_out !== 1'b1 || result !== e.res || error !== e.err) begin
            failures++;
            $display("FAIL hold_setup: got result=%b error=%b, expected result=%b error=%b",
                     result, error, e.res, e.err);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0 || result !== 8'b00101010 || error !== 1'b0) begin
                failures++;
                $display("FAIL hold_idle: got result=%b error=%b valid_out=%b, expected result=00101010 error=0 valid_out=0",
                         result, error, valid_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   bs[3] = '{0, 2, 9};
        exp_t e;
        drive(8'b10101010, bs[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) drive(8'b10101010, bs[i+1]);
            else       valid_in = 1'b0;
            e = sbq.pop_front();
            checks++;
            if (valid_out !== 1'b1 || result !== e.res || error !== e.err) begin
                failures++;
                $display("FAIL b2b_B%0d: got result=%b error=%b valid_out=%b, expected result=%b error=%b valid_out=1",
                         bs[i], result, error, valid_out, e.res, e.err);
            end
        end
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || result !== e.res || error !== e.err) begin
            failures++;
            $display("FAIL b2b_idle: got result=%b error=%b valid_out=%b, expected result=%b error=%b valid_out=0",
                     result, error, valid_out, e.res, e.err);
        end
    endtask

    task automatic test_random_stream();
        exp_t last;
        exp_t e;
        logic pend;
        last = '{res: result, err: error};
        pend = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) drive(8'($urandom), int'($urandom_range(0, 15)) - 3);
            else                           valid_in = 1'b0;
            @(negedge clk);
            pend = valid_in;
            valid_in = 1'b0;
            if (pend) begin
                e = sbq.pop_front();
                last = e;
            end
            checks++;
            if (valid_out !== pend || result !== last.res || error !== last.err) begin
                failures++;
                $display("FAIL stream_%0d: got result=%b error=%b valid_out=%b, expected result=%b error=%b valid_out=%b",
                         i, result, error, valid_out, last.res, last.err, pend);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(8'b10101010, 0);
        @(negedge clk);
        e = sbq.pop_front();
        checks++;
        if (valid_out !== 1'b1 || result !== e.res || error !== e.err) begin
            failures++;
            $display("FAIL arst_setup: got result=%b error=%b, expected result=%b error=%b",
                     result, error, e.res, e.err);
        end
        drive(8'b10101010, 3);
        void'(sbq.pop_back());
        #2 rst = 1'b1;
        #1;
        checks++;
        if (result !== 8'h00 || error !== 1'b0 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate: got result=%b error=%b valid_out=%b, expected 00000000 0 0",
                     result, error, valid_out);
        end
        @(negedge clk);
        checks++;
        if (result !== 8'h00 || error !== 1'b0 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL arst_discard: got result=%b error=%b valid_out=%b, expected 00000000 0 0",
                     result, error, valid_out);
        end
        rst = 1'b0;
        drive(8'b10101010, 0);
        @(negedge clk);
        valid_in = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (valid_out !== 1'b1 || result !== 8'b10101011 || error !== 1'b0 || e.res !== 8'b10101011) begin
            failures++;
            $display("FAIL arst_recover: got result=%b error=%b valid_out=%b, expected result=10101011 error=0 valid_out=1",
                     result, error, valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_random_stream();
        test_async_reset();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
